// File: rtl/spi_xfer_scheduler_pkg.sv
// Shared types and codes for the SPI transfer scheduler: FSM states, CS/RW codes, latched request payload.
package spi_xfer_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RST,
        ST_SETUP,
        ST_XFER,
        ST_DONE
    } state_e;

    localparam logic [1:0] CS_NONE = 2'b00;
    localparam logic [1:0] CS_S1   = 2'b01;
    localparam logic [1:0] CS_S2   = 2'b10;
    localparam logic [1:0] CS_S3   = 2'b11;

    localparam logic [1:0] RW_WR    = 2'b01;
    localparam logic [1:0] RW_RD    = 2'b10;
    localparam logic [1:0] RW_WR_RD = 2'b11;

    // Working copy of the granted client's request
    typedef struct packed {
        logic [1:0] slave;
        logic [1:0] mode;
        logic [1:0] rw;
        logic [7:0] wdata;
    } xfer_t;

endpackage

// File: rtl/spi_xfer_scheduler_rr_arbiter.sv
// Round-robin arbiter: picks the first active request at or after ptr, wrapping modulo NREQ.
module spi_xfer_scheduler_rr_arbiter #(
    parameter int unsigned NREQ  = 3,
    parameter int unsigned PTR_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  gnt_c,
    output logic [PTR_W-1:0] idx_c,
    output logic             any_c
);

    always_comb begin
        int unsigned j;
        gnt_c = '0;
        idx_c = '0;
        any_c = 1'b0;
        j     = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            j = (32'(ptr) + i) % NREQ;
            if (!any_c && req[j]) begin
                any_c    = 1'b1;
                gnt_c[j] = 1'b1;
                idx_c    = PTR_W'(j);
            end
        end
    end

endmodule

// File: rtl/spi_xfer_scheduler.sv
// Shares one SPI_Master among NREQ clients with round-robin arbitration and per-byte sequencing.
// Optional burst mode (gnt held across bytes, RST skipped) is enabled with SPI_SCHED_BURST_EN.
module spi_xfer_scheduler
    import spi_xfer_scheduler_pkg::*;
#(
    parameter int unsigned NREQ        = 3,
    parameter int unsigned XFER_CYCLES = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [2*NREQ-1:0] req_slave,
    input  logic [2*NREQ-1:0] req_mode,
    input  logic [2*NREQ-1:0] req_rw,
    input  logic [8*NREQ-1:0] req_wdata,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic [7:0]        rdata,
    output logic              busy,
    output logic              m_reset,
    output logic [1:0]        m_mode,
    output logic [1:0]        m_cs,
    output logic [1:0]        m_rw,
    output logic [7:0]        m_data_in,
    input  logic [7:0]        m_data_out
);

    localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CNT_W = $clog2(XFER_CYCLES + 1);

    state_e           state_q, state_nxt;
    xfer_t            xfer_q, xfer_nxt, req_sel;
    logic [PTR_W-1:0] owner_q, owner_nxt, ptr_q, ptr_nxt, idx_c, sel_idx;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;
    logic [NREQ-1:0]  arb_gnt_c, owner_oh;
    logic             any_c, active_nxt;

    logic [NREQ-1:0]  gnt_nxt, done_nxt;
    logic [7:0]       rdata_nxt, m_data_in_nxt;
    logic             busy_nxt, m_reset_nxt;
    logic [1:0]       m_mode_nxt, m_cs_nxt, m_rw_nxt;

`ifndef SPI_SCHED_BURST_EN
    logic unused_req_last;
    assign unused_req_last = ^req_last;
`endif

    spi_xfer_scheduler_rr_arbiter #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_arb (
        .req   (req),
        .ptr   (ptr_q),
        .gnt_c (arb_gnt_c),
        .idx_c (idx_c),
        .any_c (any_c)
    );

    // In DONE the owner's next byte is read; otherwise the arbitration winner's fields
    assign sel_idx = (state_q == ST_DONE) ? owner_q : idx_c;

    always_comb begin
        req_sel.slave = req_slave[2*32'(sel_idx) +: 2];
        req_sel.mode  = req_mode[2*32'(sel_idx) +: 2];
        req_sel.rw    = req_rw[2*32'(sel_idx) +: 2];
        req_sel.wdata = req_wdata[8*32'(sel_idx) +: 8];
    end

    // Next-state, working registers and registered-output next values
    always_comb begin
        state_nxt = state_q;
        xfer_nxt  = xfer_q;
        owner_nxt = owner_q;
        ptr_nxt   = ptr_q;
        cnt_nxt   = cnt_q;
        rdata_nxt = rdata;

        unique case (state_q)
            ST_IDLE: begin
                if (any_c) begin
                    owner_nxt = idx_c;
                    xfer_nxt  = req_sel;
                    ptr_nxt   = (32'(idx_c) == NREQ - 1) ? '0 : idx_c + PTR_W'(1);
                    if (req_sel.slave == CS_NONE) begin
                        state_nxt = ST_DONE;
                        rdata_nxt = '0;
                    end else begin
                        state_nxt = ST_RST;
                    end
                end
            end
            ST_RST:   state_nxt = ST_SETUP;
            ST_SETUP: begin
                state_nxt = ST_XFER;
                cnt_nxt   = '0;
            end
            ST_XFER: begin
                if (cnt_q == CNT_W'(XFER_CYCLES - 1)) begin
                    state_nxt = ST_DONE;
                    rdata_nxt = xfer_q.rw[1] ? m_data_out : 8'h00;
                end else begin
                    cnt_nxt = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
`ifdef SPI_SCHED_BURST_EN
                // Burst continues with fresh data; slave and mode stay from the first byte
                if (req[owner_q] && !req_last[owner_q] && xfer_q.slave != CS_NONE) begin
                    state_nxt      = ST_SETUP;
                    xfer_nxt.rw    = req_sel.rw;
                    xfer_nxt.wdata = req_sel.wdata;
                end else begin
                    state_nxt = ST_IDLE;
                end
`else
                state_nxt = ST_IDLE;
`endif
            end
            default: state_nxt = ST_IDLE;
        endcase

        owner_oh      = NREQ'(1) << owner_nxt;
        active_nxt    = (state_nxt == ST_SETUP) || (state_nxt == ST_XFER);
        gnt_nxt       = (state_nxt == ST_IDLE) ? '0 : owner_oh;
        done_nxt      = (state_nxt == ST_DONE) ? owner_oh : '0;
        busy_nxt      = (state_nxt != ST_IDLE);
        m_reset_nxt   = (state_nxt == ST_RST);
        m_mode_nxt    = active_nxt ? xfer_nxt.mode : 2'b00;
        m_data_in_nxt = active_nxt ? xfer_nxt.wdata : 8'h00;
        m_cs_nxt      = (state_nxt == ST_XFER) ? xfer_nxt.slave : CS_NONE;
        m_rw_nxt      = (state_nxt == ST_XFER) ? xfer_nxt.rw : 2'b00;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            xfer_q    <= '0;
            owner_q   <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            rdata     <= '0;
            gnt       <= '0;
            done      <= '0;
            busy      <= 1'b0;
            m_reset   <= 1'b1;
            m_mode    <= '0;
            m_cs      <= '0;
            m_rw      <= '0;
            m_data_in <= '0;
        end else begin
            state_q   <= state_nxt;
            xfer_q    <= xfer_nxt;
            owner_q   <= owner_nxt;
            ptr_q     <= ptr_nxt;
            cnt_q     <= cnt_nxt;
            rdata     <= rdata_nxt;
            gnt       <= gnt_nxt;
            done      <= done_nxt;
            busy      <= busy_nxt;
            m_reset   <= m_reset_nxt;
            m_mode    <= m_mode_nxt;
            m_cs      <= m_cs_nxt;
            m_rw      <= m_rw_nxt;
            m_data_in <= m_data_in_nxt;
        end
    end

endmodule

// File: tb/tb_spi_xfer_scheduler.sv
// Self-checking bench for spi_xfer_scheduler; SPI_Master modelled as a loopback returning the bit-reversed byte.
module tb_spi_xfer_scheduler;
    import spi_xfer_scheduler_pkg::*;

    localparam int unsigned NREQ = 3;

    typedef struct {
        logic [NREQ-1:0] vec;
        logic [7:0]      rd;
    } exp_t;

    logic              clk, reset;
    logic [NREQ-1:0]   req, req_last, gnt, done;
    logic [2*NREQ-1:0] req_slave, req_mode, req_rw;
    logic [8*NREQ-1:0] req_wdata;
    logic [7:0]        rdata, m_data_in, m_data_out;
    logic              busy, m_reset;
    logic [1:0]        m_mode, m_cs, m_rw;

    int   errors = 0;
    int   checks = 0;
    int   cs_cycles = 0;
    exp_t sb_q[$];

    function automatic logic [7:0] bitrev(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return r;
    endfunction

    assign m_data_out = bitrev(m_data_in);

    spi_xfer_scheduler #(.NREQ(NREQ), .XFER_CYCLES(10)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .req_slave  (req_slave),
        .req_mode   (req_mode),
        .req_rw     (req_rw),
        .req_wdata  (req_wdata),
        .req_last   (req_last),
        .gnt        (gnt),
        .done       (done),
        .rdata      (rdata),
        .busy       (busy),
        .m_reset    (m_reset),
        .m_mode     (m_mode),
        .m_cs       (m_cs),
        .m_rw       (m_rw),
        .m_data_in  (m_data_in),
        .m_data_out (m_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int c, input logic [7:0] rd);
        exp_t e;
        e.vec = NREQ'(1) << c;
        e.rd  = rd;
        sb_q.push_back(e);
    endtask

    task automatic set_client(input int c, input logic [1:0] sl, input logic [1:0] md,
                              input logic [1:0] rw, input logic [7:0] wd);
        req_slave[2*c +: 2] = sl;
        req_mode[2*c +: 2]  = md;
        req_rw[2*c +: 2]    = rw;
        req_wdata[8*c +: 8] = wd;
    endtask

    // Scoreboard consumer and CS activity counter
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (m_cs != CS_NONE) cs_cycles++;
            if (done != '0) begin
                if (sb_q.size() == 0) begin
                    check("done_unexpected", 32'(done), 32'(0));
                end else begin
                    e = sb_q.pop_front();
                    check("done_vec", 32'(done), 32'(e.vec));
                    check("rdata", 32'(rdata), 32'(e.rd));
                end
            end
        end
    end

    // One complete byte from client c, checking phase outputs, latency and CS window
    task automatic run_xfer(input int c, input logic [1:0] sl, input logic [1:0] md,
                            input logic [1:0] rw, input logic [7:0] wd);
        int lat;
        int cs0;
        logic [7:0] exp_rd;
        exp_rd = (sl != CS_NONE && rw[1]) ? bitrev(wd) : 8'h00;
        set_client(c, sl, md, rw, wd);
        push(c, exp_rd);
        req[c] = 1'b1;
        cs0 = cs_cycles;
        lat = 0;
        if (sl != CS_NONE) begin
            @(negedge clk); lat++;
            check("rst_gnt", 32'(gnt), 32'(NREQ'(1) << c));
            check("rst_m_reset", 32'(m_reset), 32'(1));
            @(negedge clk); lat++;
            check("setup_m_reset", 32'(m_reset), 32'(0));
            check("setup_mode", 32'(m_mode), 32'(md));
            check("setup_data_in", 32'(m_data_in), 32'(wd));
            check("setup_cs", 32'(m_cs), 32'(0));
            @(negedge clk); lat++;
            check("xfer_cs", 32'(m_cs), 32'(sl));
            check("xfer_rw", 32'(m_rw), 32'(rw));
            check("xfer_mode", 32'(m_mode), 32'(md));
        end
        while (done == '0 && lat < 40) begin
            @(negedge clk); lat++;
        end
        check("done_seen", 32'(done != '0), 32'(1));
        check("latency", 32'(lat), (sl == CS_NONE) ? 32'(1) : 32'(13));
        check("cs_window", 32'(cs_cycles - cs0), (sl == CS_NONE) ? 32'(0) : 32'(10));
        check("gnt_at_done", 32'(gnt), 32'(NREQ'(1) << c));
        req[c] = 1'b0;
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'(0));
        check("rdata_held", 32'(rdata), 32'(exp_rd));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        reset     = 1'b1;
        req       = '0;
        req_last  = '0;
        req_slave = '0;
        req_mode  = '0;
        req_rw    = '0;
        req_wdata = '0;
        repeat (2) @(negedge clk);
        check("rst_m_reset", 32'(m_reset), 32'(1));
        check("rst_gnt", 32'(gnt), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_rdata", 32'(rdata), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_cs", 32'(m_cs), 32'(0));
        check("rst_rw", 32'(m_rw), 32'(0));
        check("rst_mode", 32'(m_mode), 32'(0));
        check("rst_data_in", 32'(m_data_in), 32'(0));
        reset = 1'b0;
        @(negedge clk);
        check("m_reset_release", 32'(m_reset), 32'(0));

        // All clients together; client0 keeps requesting and is re-served after client2
        set_client(0, CS_S1, 2'b00, RW_WR_RD, 8'h11);
        set_client(1, CS_S2, 2'b01, RW_WR_RD, 8'h22);
        set_client(2, CS_S3, 2'b10, RW_WR_RD, 8'h33);
        push(0, bitrev(8'h11));
        push(1, bitrev(8'h22));
        push(2, bitrev(8'h33));
        push(0, bitrev(8'h11));
        req = 3'b111;
        for (int k = 0; k < 4; k++) begin
            lat = 0;
            while (done == '0 && lat < 40) begin
                @(negedge clk); lat++;
            end
            check("rr_done_seen", 32'(done != '0), 32'(1));
            if (k == 1) req[1] = 1'b0;
            else if (k == 2) req[2] = 1'b0;
            else if (k == 3) req[0] = 1'b0;
            @(negedge clk);
            check("rr_busy_gap", 32'(busy), 32'(0));
            if (k < 3) begin
                @(negedge clk);
                check("rr_busy_next", 32'(busy), 32'(1));
            end
        end

        // ptr now 1: write-only mode 3, then no-slave, then the reference AA byte
        run_xfer(1, CS_S2, 2'b11, RW_WR, 8'hE7);
        run_xfer(2, CS_NONE, 2'b00, RW_WR_RD, 8'h5A);
        run_xfer(0, CS_S1, 2'b00, RW_WR_RD, 8'hAA);

        // Reset in the middle of XFER aborts without done
        set_client(2, CS_S3, 2'b00, RW_WR_RD, 8'h0F);
        req[2] = 1'b1;
        repeat (6) @(negedge clk);
        check("abort_in_xfer", 32'(m_cs), 32'(CS_S3));
        reset = 1'b1;
        #1;
        check("abort_cs", 32'(m_cs), 32'(0));
        check("abort_m_reset", 32'(m_reset), 32'(1));
        check("abort_gnt", 32'(gnt), 32'(0));
        check("abort_busy", 32'(busy), 32'(0));
        check("abort_done", 32'(done), 32'(0));
        req = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("abort_release", 32'(m_reset), 32'(0));
        run_xfer(0, CS_S1, 2'b01, RW_RD, 8'h1E);

`ifdef SPI_SCHED_BURST_EN
        begin : burst
            int mr;
            int lost;
            set_client(1, CS_S2, 2'b01, RW_WR_RD, 8'hCC);
            req_last[1] = 1'b0;
            push(1, 8'h33);
            push(1, 8'h89);
            req[1] = 1'b1;
            mr = 0;
            lost = 0;
            lat = 0;
            while (done == '0 && lat < 40) begin
                @(negedge clk); lat++;
                if (m_reset) mr++;
            end
            check("burst_first_done", 32'(done != '0), 32'(1));
            req_wdata[15:8] = 8'h91;
            req_last[1]     = 1'b1;
            lat = 0;
            do begin
                @(negedge clk); lat++;
                if (m_reset) mr++;
                if (gnt != 3'b010) lost++;
            end while (done == '0 && lat < 40);
            check("burst_second_lat", 32'(lat), 32'(12));
            check("burst_one_rst", 32'(mr), 32'(1));
            check("burst_gnt_held", 32'(lost), 32'(0));
            req[1]      = 1'b0;
            req_last[1] = 1'b0;
            @(negedge clk);
            check("burst_end_busy", 32'(busy), 32'(0));
        end
`endif

        repeat (3) @(negedge clk);
        check("sb_empty", 32'(sb_q.size()), 32'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
